// File: rtl/grostl_pkg.sv
// -----------------------------------------------------------------------------
// grostl_pkg
// Shared definitions for the Groestl MixBytes scheduler:
//   - legal column counts for the two Groestl variants
//   - the 8-byte column type fed to the column MixBytes unit
//   - scheduler FSM states and requester tags
//   - GF(2^8) helpers (polynomial 0x11b) used by the column unit
// No ports; imported by grostl_mix_col and grostl_mix_sched.
// -----------------------------------------------------------------------------
package grostl_pkg;

    localparam int NCOLS_256 = 8;    // 512-bit state
    localparam int NCOLS_512 = 16;   // 1024-bit state

    // Element 0 is row 0 and sits in the most significant byte, matching the
    // big-endian byte order of the state vector.
    typedef logic [0:7][7:0] col_t;

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        DONE
    } fsm_e;

    localparam logic ID_P = 1'b0;
    localparam logic ID_Q = 1'b1;

    // Circulant row 0; row i uses this row rotated right by i positions.
    localparam col_t MB_ROW0 = {8'h02, 8'h02, 8'h03, 8'h04,
                                8'h05, 8'h03, 8'h05, 8'h07};

    // Multiply by x (0x02) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant; every MixBytes coefficient fits in 3 bits.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [2:0] c);
        logic [7:0] a2;
        logic [7:0] a4;
        a2 = gf_xtime(a);
        a4 = gf_xtime(a2);
        return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^ (c[2] ? a4 : 8'h00);
    endfunction

endpackage

// File: rtl/grostl_mix_col.sv
// -----------------------------------------------------------------------------
// grostl_mix_col
// Purely combinational MixBytes for one 8-byte state column.
//   din  : column in, din[63:56] = row 0 ... din[7:0] = row 7
//   dout : mixed column, same byte order
// dout[i] = XOR over j of C[i][j] * din[j], with C[i][j] = MB_ROW0[(j - i) mod 8].
// -----------------------------------------------------------------------------
module grostl_mix_col
    import grostl_pkg::*;
(
    input  logic [63:0] din,
    output logic [63:0] dout
);

    col_t       d;
    col_t       m;
    logic [2:0] k;

    assign d = din;

    // NOTE: every variable written here gets a value before any branch or
    // loop can skip it; otherwise synthesis infers a latch to hold the old one.
    always_comb begin
        m = '0;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                // 3-bit truncation performs the mod-8 rotation.
                k    = 3'(j - i);
                m[i] = m[i] ^ gf_mul(d[j], MB_ROW0[k][2:0]);
            end
        end
    end

    assign dout = m;

endmodule

// File: rtl/grostl_mix_sched.sv
// -----------------------------------------------------------------------------
// grostl_mix_sched
// Shares one column MixBytes unit between the P and Q permutation requesters.
// A granted state is loaded into state_q, mixed in place one column per
// cycle, then offered on the output with a requester tag.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   p_valid/p_ready/p_state P requester handshake and state
//   q_valid/q_ready/q_state Q requester handshake and state
//   out_valid/out_ready     result handshake
//   out_state, out_id       mixed state and tag (0 = P, 1 = Q)
//   busy                    high whenever the FSM is not IDLE
//
// NCOLS must be 8 or 16; SW is derived and must not be overridden.
// -----------------------------------------------------------------------------
module grostl_mix_sched
    import grostl_pkg::*;
#(
    parameter int NCOLS = NCOLS_256,
    parameter int SW    = NCOLS * 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_valid,
    output logic          p_ready,
    input  logic [SW-1:0] p_state,
    input  logic          q_valid,
    output logic          q_ready,
    input  logic [SW-1:0] q_state,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_state,
    output logic          out_id,
    output logic          busy
);

    localparam int CW = $clog2(NCOLS);

    fsm_e          fsm_q;
    fsm_e          fsm_n;
    logic [SW-1:0] state_q;
    logic [CW-1:0] col_q;
    logic          id_q;
    logic          prio;
    logic          grant_q;
    logic          last_col;
    logic [CW+5:0] col_lsb;
    logic [63:0]   col_in;
    logic [63:0]   col_out;

    // Column j lives at bits [SW-1-64j -: 64]; with NCOLS a power of two the
    // reversed column index ~col_q gives its LSB-based offset directly.
    assign col_lsb  = {~col_q, 6'd0};
    assign col_in   = state_q[col_lsb +: 64];
    assign last_col = (col_q == CW'(NCOLS - 1));

    grostl_mix_col u_col (
        .din  (col_in),
        .dout (col_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_n;
    end

    always_comb begin
        fsm_n     = fsm_q;
        grant_q   = 1'b0;
        p_ready   = 1'b0;
        q_ready   = 1'b0;
        out_valid = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                grant_q = q_valid && (!p_valid || prio);
                // Readies are combinational from the valids, so hold them low
                // while reset is asserted to keep every output at zero.
                p_ready = !rst && p_valid && !grant_q;
                q_ready = !rst && grant_q;
                if (p_valid || q_valid) fsm_n = MIX;
            end
            MIX: begin
                if (last_col) fsm_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_n = IDLE;
            end
            default: fsm_n = IDLE;
        endcase
    end

    // NOTE: state_q is a plain register rather than a RAM, so it takes the
    // reset too; out_state is driven straight from it and must read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            col_q   <= '0;
            id_q    <= ID_P;
            prio    <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (p_ready || q_ready) begin
                        state_q <= grant_q ? q_state : p_state;
                        id_q    <= grant_q ? ID_Q : ID_P;
                        col_q   <= '0;
                    end
                end
                MIX: begin
                    state_q[col_lsb +: 64] <= col_out;
                    // Parks on the last column instead of wrapping.
                    if (!last_col) col_q <= col_q + CW'(1);
                end
                DONE: begin
                    if (out_ready) prio <= ~id_q;
                end
                default: ;
            endcase
        end
    end

    assign out_state = state_q;
    assign out_id    = id_q;
    assign busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_grostl_mix_sched.sv
module tb_grostl_mix_sched;
    import grostl_pkg::*;

    localparam int NC8  = NCOLS_256;
    localparam int NC16 = NCOLS_512;
    localparam int SW8  = NC8 * 64;
    localparam int SW16 = NC16 * 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            p_valid8, q_valid8, p_ready8, q_ready8;
    logic            out_valid8, out_ready8, out_id8, busy8;
    logic [SW8-1:0]  p_state8, q_state8, out_state8;
    logic            p_valid16, q_valid16, p_ready16, q_ready16;
    logic            out_valid16, out_ready16, out_id16, busy16;
    logic [SW16-1:0] p_state16, q_state16, out_state16;

    grostl_mix_sched #(.NCOLS(NC8)) dut8 (
        .clk(clk), .rst(rst),
        .p_valid(p_valid8), .p_ready(p_ready8), .p_state(p_state8),
        .q_valid(q_valid8), .q_ready(q_ready8), .q_state(q_state8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_state(out_state8), .out_id(out_id8), .busy(busy8)
    );

    grostl_mix_sched #(.NCOLS(NC16)) dut16 (
        .clk(clk), .rst(rst),
        .p_valid(p_valid16), .p_ready(p_ready16), .p_state(p_state16),
        .q_valid(q_valid16), .q_ready(q_ready16), .q_state(q_state16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_state(out_state16), .out_id(out_id16), .busy(busy16)
    );

    typedef struct {
        logic [1023:0] st;
        logic          id;
    } exp_t;

    exp_t exp8[$];
    exp_t exp16[$];
    logic acc_ids[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_acc8   = 0;
    int n_acc16  = 0;
    int acc_cyc8, acc_cyc16;
    logic prio8, prev_ov8, prev_hold8, held_id8, prev_ov16;
    logic [SW8-1:0] held_st8, last_st8;
    logic last_id8;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else begin
            int w;
            w = 0;
            for (int i = 15; i >= 0; i--) if (act[i*64 +: 64] !== req[i*64 +: 64]) w = i;
            $display("FAIL %s: word %0d got %h required %h (t=%0t)",
                     name, w, act[w*64 +: 64], req[w*64 +: 64], $time);
        end
    endtask

    // ---------------- reference model: GF(2^8) by long division ----------------
    function automatic int gmul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int bi = 14; bi >= 8; bi--) if (((p >> bi) & 1) != 0) p = p ^ ('h11b << (bi - 8));
        return p;
    endfunction

    function automatic logic [1023:0] mix_ref(input logic [1023:0] s, input int nc);
        int row0[8];
        int b[128];
        int o[128];
        int sw;
        int acc;
        logic [1023:0] r;
        row0 = '{2, 2, 3, 4, 5, 3, 5, 7};
        sw = nc * 64;
        r  = '0;
        for (int k = 0; k < nc * 8; k++) b[k] = int'(s[sw-8-8*k +: 8]);
        for (int j = 0; j < nc; j++)
            for (int i = 0; i < 8; i++) begin
                acc = 0;
                for (int c = 0; c < 8; c++) acc = acc ^ gmul(row0[(c - i + 8) % 8], b[8*j + c]);
                o[8*j + i] = acc;
            end
        for (int k = 0; k < nc * 8; k++) r[sw-8-8*k +: 8] = 8'(o[k]);
        return r;
    endfunction

    function automatic logic [1023:0] rand_wide();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- monitor / scoreboard for the 8-column instance ----------------
    always @(negedge clk) begin
        logic exp_q;
        exp_t e;
        if (rst) begin
            exp8.delete();
            prio8      = 1'b0;
            prev_ov8   = 1'b0;
            prev_hold8 = 1'b0;
        end else begin
            if (p_ready8 || q_ready8) begin
                check("ready_excl8", p_ready8 && q_ready8, 0);
                check("ready_busy8", busy8, 0);
            end
            if (!busy8 && (p_valid8 || q_valid8)) begin
                exp_q = q_valid8 && (!p_valid8 || prio8);
                check("grant_p8", p_ready8, p_valid8 && !exp_q);
                check("grant_q8", q_ready8, exp_q);
            end
            if (p_valid8 && p_ready8) begin
                exp8.push_back('{st: mix_ref(p_state8, NC8), id: ID_P});
                acc_ids.push_back(ID_P);
                acc_cyc8 = cyc;
                n_acc8++;
            end else if (q_valid8 && q_ready8) begin
                exp8.push_back('{st: mix_ref(q_state8, NC8), id: ID_Q});
                acc_ids.push_back(ID_Q);
                acc_cyc8 = cyc;
                n_acc8++;
            end
            if (prev_hold8) begin
                check("hold_valid8", out_valid8, 1);
                check("hold_state8", out_state8, held_st8);
                check("hold_id8", out_id8, held_id8);
            end
            prev_hold8 = out_valid8 && !out_ready8;
            held_st8   = out_state8;
            held_id8   = out_id8;
            if (out_valid8 && !prev_ov8) check("latency8", cyc - acc_cyc8, NC8 + 1);
            prev_ov8 = out_valid8;
            if (out_valid8 && out_ready8) begin
                if (exp8.size() == 0) check("unexpected_out8", 1, 0);
                else begin
                    e = exp8.pop_front();
                    check("out_state8", out_state8, e.st);
                    check("out_id8", out_id8, e.id);
                    prio8    = ~e.id;
                    last_st8 = out_state8;
                    last_id8 = out_id8;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard for the 16-column instance ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp16.delete();
            prev_ov16 = 1'b0;
        end else begin
            if (p_valid16 && p_ready16) begin
                exp16.push_back('{st: mix_ref(p_state16, NC16), id: ID_P});
                acc_cyc16 = cyc;
                n_acc16++;
            end else if (q_valid16 && q_ready16) begin
                exp16.push_back('{st: mix_ref(q_state16, NC16), id: ID_Q});
                acc_cyc16 = cyc;
                n_acc16++;
            end
            if (out_valid16 && !prev_ov16) check("latency16", cyc - acc_cyc16, NC16 + 1);
            prev_ov16 = out_valid16;
            if (out_valid16 && out_ready16) begin
                if (exp16.size() == 0) check("unexpected_out16", 1, 0);
                else begin
                    e = exp16.pop_front();
                    check("out_state16", out_state16, e.st);
                    check("out_id16", out_id16, e.id);
                end
            end
        end
    end

    // Raise the selected valids, wait for one acceptance, drop both.
    task automatic issue8(input bit do_p, input bit do_q);
        int start;
        int guard;
        start = n_acc8;
        guard = 0;
        p_valid8 = do_p;
        q_valid8 = do_q;
        while (n_acc8 == start && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (n_acc8 == start) check("accept_timeout8", 1, 0);
        p_valid8 = 1'b0;
        q_valid8 = 1'b0;
    endtask

    task automatic drain8();
        int guard;
        guard = 0;
        while ((exp8.size() != 0 || busy8) && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp8.size() != 0 || busy8) check("drain_timeout8", 1, 0);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int seen;
        int guard;
        rst = 1'b1;
        p_valid8 = 1'b1; q_valid8 = 1'b1; out_ready8 = 1'b0;
        p_state8 = '1;   q_state8 = '1;
        p_valid16 = 1'b0; q_valid16 = 1'b0; out_ready16 = 1'b1;
        p_state16 = '0;   q_state16 = '0;
        repeat (2) @(negedge clk);

        // Reset state, with both requesters already asking.
        check("rst_out_valid8", out_valid8, 0);
        check("rst_out_state8", out_state8, 0);
        check("rst_out_id8", out_id8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_p_ready8", p_ready8, 0);
        check("rst_q_ready8", q_ready8, 0);
        check("rst_out_valid16", out_valid16, 0);
        check("rst_out_state16", out_state16, 0);
        @(posedge clk); #1;
        p_valid8 = 1'b0; q_valid8 = 1'b0;
        rst = 1'b0;
        out_ready8 = 1'b1;

        // Directed P: byte 0 = 0x01 yields the inverted circulant column.
        p_state8 = {8'h01, 504'h0};
        issue8(1, 0);
        drain8();
        check("dir_p_state", last_st8, {64'h0207050305040302, 448'h0});
        check("dir_p_id", last_id8, 0);

        // Directed Q: byte 0 = 0x80 exercises the reduction.
        q_state8 = {8'h80, 504'h0};
        issue8(0, 1);
        drain8();
        check("dir_q_row0", last_st8[SW8-1 -: 8], 8'h1b);
        check("dir_q_row1", last_st8[SW8-9 -: 8], 8'had);
        check("dir_q_id", last_id8, 1);

        // Both requesters held high from reset: strict alternation.
        pulse_rst();
        acc_ids.delete();
        p_state8 = SW8'(rand_wide());
        q_state8 = SW8'(rand_wide());
        p_valid8 = 1'b1; q_valid8 = 1'b1;
        base = n_acc8; seen = n_acc8; guard = 0;
        while (n_acc8 - base < 4 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
            if (n_acc8 != seen) begin
                seen = n_acc8;
                p_state8 = SW8'(rand_wide());
                q_state8 = SW8'(rand_wide());
            end
        end
        p_valid8 = 1'b0; q_valid8 = 1'b0;
        drain8();
        check("order_count", acc_ids.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("order%0d", i), (i < acc_ids.size()) ? acc_ids[i] : 1'bx, i % 2);

        // Output back-pressure in DONE with both requesters waiting.
        out_ready8 = 1'b0;
        p_state8 = SW8'(rand_wide());
        issue8(1, 0);
        guard = 0;
        while (!out_valid8 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_reached", out_valid8, 1);
        p_valid8 = 1'b1; q_valid8 = 1'b1;
        base = n_acc8;
        repeat (10) begin @(posedge clk); #1; end
        check("no_accept_in_done", n_acc8, base);
        out_ready8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_done", busy8, 0);
        check("other_side_q_ready", q_ready8, 1);
        check("other_side_p_ready", p_ready8, 0);
        @(posedge clk); #1;
        p_valid8 = 1'b0; q_valid8 = 1'b0;
        drain8();
        check("other_side_id", last_id8, 1);

        // Reset in the middle of MIX, at col_q = 3.
        p_state8 = SW8'(rand_wide());
        issue8(1, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("mid_busy", busy8, 1);
        p_valid8 = 1'b1; q_valid8 = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid8, 0);
        check("mid_rst_out_state", out_state8, 0);
        check("mid_rst_out_id", out_id8, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_p_ready", p_ready8, 0);
        check("mid_rst_q_ready", q_ready8, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        p_valid8 = 1'b0; q_valid8 = 1'b0;
        // Fresh prio after reset: both valid must grant P.
        p_state8 = SW8'(rand_wide());
        q_state8 = SW8'(rand_wide());
        issue8(1, 1);
        drain8();
        check("post_rst_id", last_id8, 0);

        // Random traffic with random back-pressure and withdrawn requests.
        seen = n_acc8;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            out_ready8 = ($urandom % 4) != 0;
            if (n_acc8 != seen) begin
                seen = n_acc8;
                if (acc_ids[$] == ID_P) p_valid8 = 1'b0;
                else                    q_valid8 = 1'b0;
            end
            if (p_valid8 && ($urandom % 8) == 0) p_valid8 = 1'b0;
            if (q_valid8 && ($urandom % 8) == 0) q_valid8 = 1'b0;
            if (!p_valid8 && ($urandom % 3) == 0) begin
                p_valid8 = 1'b1;
                p_state8 = SW8'(rand_wide());
            end
            if (!q_valid8 && ($urandom % 3) == 0) begin
                q_valid8 = 1'b1;
                q_state8 = SW8'(rand_wide());
            end
        end
        p_valid8 = 1'b0; q_valid8 = 1'b0;
        out_ready8 = 1'b1;
        drain8();
        check("drained8", exp8.size(), 0);

        // 16-column instance: random 1024-bit states on both sides.
        for (int r = 0; r < 4; r++) begin
            base = n_acc16;
            guard = 0;
            if (r % 2 == 0) begin p_state16 = rand_wide(); p_valid16 = 1'b1; end
            else            begin q_state16 = rand_wide(); q_valid16 = 1'b1; end
            while (n_acc16 == base && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (n_acc16 == base) check("accept_timeout16", 1, 0);
            p_valid16 = 1'b0; q_valid16 = 1'b0;
            guard = 0;
            while ((exp16.size() != 0 || busy16) && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        check("drained16", exp16.size(), 0);
        check("count16", n_acc16, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
